product_accumulator: RTL and testbench

- Downstream consumer of the dual-channel multiplier stage.
- Samples each 16-bit product `m` on the rising edge of the multiplier's `ok` strobe and accumulates batches of N products into a wide sum.
- Hands each completed batch sum to the next stage over the team's standard `dav_`/`rfd` handshake, with this block as producer.
- Products that arrive while a batch is being handed over are dropped and counted.

---
 rtl/product_accumulator.sv | 153 +++++++++++++++
 tb/tb_product_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Batch accumulator: sums N products per batch and hands the sum downstream over dav_/rfd.
// Optional PRODUCT_ACCUMULATOR_MAX_EN adds a `max` output with the largest product of the batch.
module product_accumulator #(
  parameter int unsigned N      = 4,
  parameter int unsigned SUM_W  = 18,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       m,
  input  logic              ok,
  output logic [SUM_W-1:0]  sum,
  output logic              dav_,
  input  logic              rfd,
  output logic              busy,
  output logic [DROP_W-1:0] drops
`ifdef PRODUCT_ACCUMULATOR_MAX_EN
  ,
  output logic [15:0]       max
`endif
);

  localparam int unsigned K_W = $clog2(N);

  localparam logic [1:0] S_ACC = 2'd0;
  localparam logic [1:0] S_OUT = 2'd1;
  localparam logic [1:0] S_REL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ok_q, ok_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              dav_q, dav_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drops_q, drops_d;

  logic new_c;
  logic take_c;
  logic last_c;

  // ok_q resets high so an ok already asserted at reset release is not an edge
  assign new_c  = ok & ~ok_q;
  assign take_c = new_c && (state_q == S_ACC);
  assign last_c = take_c && (k_q == K_W'(N - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_ACC;
      ok_q    <= 1'b1;
      acc_q   <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      dav_q   <= 1'b1;
      busy_q  <= 1'b0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      ok_q    <= ok_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      dav_q   <= dav_d;
      busy_q  <= busy_d;
      drops_q <= drops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ok_d    = ok;
    acc_d   = acc_q;
    k_d     = k_q;
    sum_d   = sum_q;
    dav_d   = dav_q;
    drops_d = drops_q;

    case (state_q)
      S_ACC: begin
        if (last_c) begin
          sum_d   = acc_q + SUM_W'(m);
          acc_d   = '0;
          k_d     = '0;
          dav_d   = 1'b0;
          state_d = S_OUT;
        end else if (take_c) begin
          acc_d = acc_q + SUM_W'(m);
          k_d   = k_q + K_W'(1);
        end
      end
      S_OUT: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (rfd) begin
          state_d = S_ACC;
        end
      end
      default: begin
        dav_d   = 1'b1;
        state_d = S_ACC;
      end
    endcase

    // Edges seen during handover, including the turnaround cycle, are lost
    if (new_c && (state_q != S_ACC) && (drops_q != {DROP_W{1'b1}})) begin
      drops_d = drops_q + DROP_W'(1);
    end

    busy_d = (state_d != S_ACC);
  end

  assign sum   = sum_q;
  assign dav_  = dav_q;
  assign busy  = busy_q;
  assign drops = drops_q;

`ifdef PRODUCT_ACCUMULATOR_MAX_EN
  logic [15:0] run_max_q, run_max_d;
  logic [15:0] max_q, max_d;
  logic [15:0] big_c;

  assign big_c = (m > run_max_q) ? m : run_max_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_max_q <= '0;
      max_q     <= '0;
    end else begin
      run_max_q <= run_max_d;
      max_q     <= max_d;
    end
  end

  // Running max restarts at every batch boundary; result latches with sum
  always_comb begin
    run_max_d = run_max_q;
    max_d     = max_q;
    if (last_c) begin
      max_d     = big_c;
      run_max_d = '0;
    end else if (take_c) begin
      run_max_d = big_c;
    end
  end

  assign max = max_q;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed batches plus random batches
// checked against a queue-based batch model; a second instance uses DROP_W=2 for saturation.
module tb_product_accumulator;

  localparam int unsigned N     = 4;
  localparam int unsigned SUM_W = 18;

  logic             clock;
  logic             reset;
  logic [15:0]      m;
  logic             ok;
  logic             rfd;
  logic [SUM_W-1:0] sum_a, sum_b;
  logic             dav_a, dav_b;
  logic             busy_a, busy_b;
  logic [7:0]       drops_a;
  logic [1:0]       drops_b;
`ifdef PRODUCT_ACCUMULATOR_MAX_EN
  logic [15:0]      max_a, max_b;
`endif

  product_accumulator #(.N(N), .SUM_W(SUM_W), .DROP_W(8)) u_dut (
    .clock(clock), .reset(reset), .m(m), .ok(ok), .sum(sum_a), .dav_(dav_a),
    .rfd(rfd), .busy(busy_a), .drops(drops_a)
`ifdef PRODUCT_ACCUMULATOR_MAX_EN
    , .max(max_a)
`endif
  );

  product_accumulator #(.N(N), .SUM_W(SUM_W), .DROP_W(2)) u_sat (
    .clock(clock), .reset(reset), .m(m), .ok(ok), .sum(sum_b), .dav_(dav_b),
    .rfd(rfd), .busy(busy_b), .drops(drops_b)
`ifdef PRODUCT_ACCUMULATOR_MAX_EN
    , .max(max_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Batch-level reference model
  int q[$];
  int exp_sum  = 0;
  int exp_max  = 0;
  int mdrops   = 0;
  bit mbusy    = 0;
  bit mrel     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int sat;
    sat = (mdrops > 3) ? 3 : mdrops;
    check_eq({tag, ".dav_"},   32'(dav_a),   32'((mbusy && !mrel) ? 0 : 1));
    check_eq({tag, ".busy"},   32'(busy_a),  32'(mbusy));
    check_eq({tag, ".sum"},    32'(sum_a),   32'(exp_sum));
    check_eq({tag, ".drops"},  32'(drops_a), 32'((mdrops > 255) ? 255 : mdrops));
    check_eq({tag, ".sum_b"},  32'(sum_b),   32'(exp_sum));
    check_eq({tag, ".drops_b"}, 32'(drops_b), 32'(sat));
`ifdef PRODUCT_ACCUMULATOR_MAX_EN
    check_eq({tag, ".max"},    32'(max_a),   32'(exp_max));
    check_eq({tag, ".max_b"},  32'(max_b),   32'(exp_max));
`endif
  endtask

  // Starts and ends right after a falling edge
  task automatic send_product(input int v, input int hold, input int low);
    int s;
    int mx;
    m  = 16'(v);
    ok = 1'b1;
    if (!mbusy) begin
      q.push_back(v);
      if (q.size() == N) begin
        s = 0;
        mx = 0;
        foreach (q[i]) begin
          s += q[i];
          if (q[i] > mx) mx = q[i];
        end
        exp_sum = s;
        exp_max = mx;
        q.delete();
        mbusy = 1;
        mrel  = 0;
      end
    end else begin
      mdrops++;
    end
    @(negedge clock);
    check_state("prod");
    repeat (hold - 1) @(negedge clock);
    ok = 1'b0;
    m  = 16'($urandom);
    repeat (low) @(negedge clock);
  endtask

  task automatic handshake(input int wait_cyc, input int low_cyc);
    int t;
    t = 0;
    while (dav_a !== 1'b0 && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (t == 20) check_eq("dav_wait_timeout", 32'(dav_a), 32'd0);
    check_state("out");
    repeat (wait_cyc) @(negedge clock);
    check_state("out_hold");
    rfd = 1'b0;
    @(negedge clock);
    mrel = 1;
    check_state("rel");
    repeat (low_cyc - 1) @(negedge clock);
    rfd = 1'b1;
    @(negedge clock);
    mbusy = 0;
    mrel  = 0;
    check_state("idle");
  endtask

  task automatic model_reset();
    q.delete();
    exp_sum = 0;
    exp_max = 0;
    mdrops  = 0;
    mbusy   = 0;
    mrel    = 0;
  endtask

  initial begin
    int b1[8] = '{140, 175, 210, 245, 280, 350, 420, 490};

    reset = 1'b1;
    ok    = 1'b1;
    m     = 16'd1000;
    rfd   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_state("reset");
    // ok held high across reset release must not count as a product
    repeat (3) @(negedge clock);
    check_state("reset_okhigh");
    ok = 1'b0;
    repeat (2) @(negedge clock);

    // Single batch, then a back-to-back second batch
    for (int i = 0; i < 4; i++) send_product(b1[i], 3, 1);
    check_eq("single.sum", 32'(sum_a), 32'd770);
    handshake(0, 1);
    for (int i = 4; i < 8; i++) send_product(b1[i], 2, 1);
    check_eq("b2b.sum", 32'(sum_a), 32'd1540);
    handshake(1, 2);

    // Overflow bound
    for (int i = 0; i < 4; i++) send_product(65535, 1, 1);
    check_eq("ovf.sum", 32'(sum_a), 32'd262140);
    handshake(0, 1);

    // Stalled downstream: 5 drops saturate the 2-bit counter at 3
    for (int i = 0; i < 4; i++) send_product(b1[i], 1, 1);
    for (int i = 0; i < 5; i++) send_product(1000 + i, 1, 1);
    check_eq("stall.sum", 32'(sum_a), 32'd770);
    check_eq("stall.drops_b", 32'(drops_b), 32'd3);
    handshake(0, 1);
    for (int i = 4; i < 8; i++) send_product(b1[i], 1, 2);
    check_eq("after_stall.sum", 32'(sum_a), 32'd1540);
    handshake(2, 1);

    // Random batches with random strobe timing and downstream latency
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 4; i++)
        send_product(int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)),
                     int'($urandom_range(1, 3)));
      handshake(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    // Async reset while sum is being offered
    for (int i = 0; i < 4; i++) send_product(b1[i], 1, 1);
    check_eq("pre_rst.dav_", 32'(dav_a), 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) send_product(140, 2, 1);
    check_eq("post_rst.sum", 32'(sum_a), 32'd560);
    handshake(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
